ysyx_23060208_dsram_axi_slave: RTL and testbench
================================================

YSYX_23060208_DSRAM_AXI_SLAVE -- requirements
Module: ysyx_23060208_dsram_axi_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000; byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024; number of 64-bit memory words.
REQ-003 SHALL have parameter FIXED_DELAY, default 2; response latency in cycles when RAND_DELAY=0.
REQ-004 SHALL have parameter RAND_DELAY, default 0; 1 selects LFSR-derived latency.
REQ-005 SHALL have port clock, input, 1 bit; sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit; asynchronous, active-high.
REQ-007 SHALL have AW inputs awvalid(1), awaddr(32), awid(4), awlen(8), awsize(3), awburst(2), and output awready(1).
REQ-008 SHALL have W inputs wvalid(1), wdata(64), wstrb(8), wlast(1), and output wready(1).
REQ-009 SHALL have B outputs bvalid(1), bresp(2), bid(4), and input bready(1).
REQ-010 SHALL have AR inputs arvalid(1), araddr(32), arid(4), arlen(8), arsize(3), arburst(2), and output arready(1).
REQ-011 SHALL have R outputs rvalid(1), rdata(64), rresp(2), rlast(1), rid(4), and input rready(1).

Function
REQ-012 Read and write paths SHALL be independent FSMs; each handles one single-beat transaction at a time.
REQ-013 Read FSM states: R_IDLE, R_DELAY, R_RESP. arready=1 only in R_IDLE.
- R_IDLE -> R_DELAY on arvalid&&arready.
- In that cycle: latch araddr, arid, arsize, arlen; load the delay counter.
REQ-014 R_DELAY: decrement the counter each cycle; at 0 go to R_RESP and register rdata/rresp/rid, rlast=1.
- Delay D=0 SHALL give rvalid in cycle T+1, where T is the AR handshake cycle.
- General case: rvalid first high in cycle T+1+D.
REQ-015 R_RESP: hold rvalid and all R outputs stable until rready.
- On the handshake, go to R_IDLE.
- Drop rvalid; arready is high the next cycle.
REQ-016 Write FSM states: W_IDLE, W_DATA, W_DELAY, W_RESP.
- awready=1 only in W_IDLE; wready=1 only in W_DATA.
- W data arriving before the AW handshake SHALL NOT be accepted.
REQ-017 AW handshake: latch awaddr, awid, awsize, awlen; go to W_DATA.
- W handshake: write each byte lane i where wstrb[i]=1 and the address is legal; load the delay counter; go to W_DELAY.
REQ-018 W_DELAY counts as in REQ-014, then goes to W_RESP with bvalid=1 and bid=latched awid.
- bvalid stays high until bready; then go to W_IDLE.
REQ-019 Word index SHALL be (addr-BASE_ADDR)>>3. rdata SHALL be the whole 64-bit word; lane selection is the master's job.
REQ-020 Address is legal iff BASE_ADDR <= addr < BASE_ADDR+8*DEPTH_WORDS. Otherwise:
- resp=2'b11 (DECERR);
- rdata=0;
- no memory write.
REQ-021 For a legal address with len!=0 or size>3: resp=2'b10 (SLVERR), single beat still returned (rlast=1), and no write. Otherwise resp=2'b00.
REQ-022 Read data SHALL be sampled from memory on the R_DELAY->R_RESP transition.
- A write to the same word whose W handshake occurs in an earlier or the same cycle SHALL be visible.
REQ-023 Delay value D:
- RAND_DELAY=0: D=FIXED_DELAY.
- RAND_DELAY=1: D=lfsr[1:0], where the 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advances every cycle.
REQ-024 Simultaneous AR and AW handshakes in one cycle SHALL both be accepted, with no ordering between them.

Reset
REQ-025 While reset=1, the module SHALL drive:
- arready=1, awready=1;
- wready=0, rvalid=0, bvalid=0, rlast=0;
- rdata=0, rresp=0, bresp=0, rid=0, bid=0;
- both FSMs in IDLE, LFSR=8'hA5.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately.
- No response is produced afterwards.
- Memory contents SHALL NOT be reset; a W handshake already completed stays written.

Verification
REQ-027 Write 64'h1122334455667788, wstrb=8'hFF, to 32'h8000_0010, FIXED_DELAY=2, bready=1 -> bvalid high exactly 3 cycles after the W handshake, bresp=00, bid=awid.
REQ-028 Read 32'h8000_0010, arid=4'h7 -> rvalid at T+3, rdata=64'h1122334455667788, rid=7, rlast=1, rresp=00. Holding rready=0 for 5 cycles -> outputs stable, arready=0.
REQ-029 Write 64'hAAAA_AAAA_0000_00BB with wstrb=8'h01, then read the same word -> rdata=64'h11223344556677BB.
REQ-030 Read 32'h2000_0000 -> rresp=11, rdata=0. Write to 32'h2000_0000 -> bresp=11, and memory is unchanged.
REQ-031 arlen=8'h3 on a legal address -> one beat, rresp=10, rlast=1. Reset pulsed in W_DELAY -> bvalid never asserts, awready=1 after reset.
REQ-032 RAND_DELAY=1, 200 back-to-back reads -> every latency is in 1..4 cycles and every rid matches its arid.

Source files
------------

// File: rtl/ysyx_23060208_dsram_axi_slave.sv
// Single-beat AXI4 slave backed by a 64-bit word RAM, with fixed or
// LFSR-derived response latency on independent read and write paths.
module ysyx_23060208_dsram_axi_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned FIXED_DELAY = 2,
  parameter bit          RAND_DELAY  = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W    = 8;
  localparam logic [32:0] ADDR_END = 33'(BASE_ADDR) + 33'(8 * DEPTH_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_DELAY, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_DELAY, W_RESP} w_state_e;

  function automatic logic [1:0] resp_of(input logic [31:0] a, input logic [7:0] len,
                                         input logic [2:0] size);
    if (!({1'b0, a} >= {1'b0, BASE_ADDR} && {1'b0, a} < ADDR_END)) return RESP_DECERR;
    if (len != 8'd0 || size > 3'd3) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - BASE_ADDR) >> 3);
  endfunction

  logic [63:0]      mem [DEPTH_WORDS];
  logic [7:0]       lfsr;
  r_state_e         r_state;
  w_state_e         w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [31:0]      ar_addr_q, aw_addr_q;
  logic [3:0]       ar_id_q, aw_id_q;
  logic [7:0]       ar_len_q, aw_len_q;
  logic [2:0]       ar_size_q, aw_size_q;

  logic             ar_fire_c, aw_fire_c, w_fire_c, rd_done_c, wr_done_c;
  logic [CNT_W-1:0] delay_c;
  logic [1:0]       wr_resp_c, rd_resp_c;
  logic [IDX_W-1:0] wr_idx_c, rd_idx_c;
  logic [31:0]      rd_addr_c;
  logic [7:0]       rd_len_c;
  logic [2:0]       rd_size_c;
  logic [3:0]       rd_id_c;
  logic [63:0]      rd_word_c;
  logic             unused_sigs;

  assign unused_sigs = ^{awburst, arburst, wlast};

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free running
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign delay_c   = RAND_DELAY ? CNT_W'(lfsr[1:0]) : CNT_W'(FIXED_DELAY);
  assign ar_fire_c = arvalid && arready;
  assign aw_fire_c = awvalid && awready;
  assign w_fire_c  = wvalid && wready;
  assign wr_resp_c = resp_of(aw_addr_q, aw_len_q, aw_size_q);
  assign wr_idx_c  = word_idx(aw_addr_q);

  // Zero-delay reads sample straight from the AR channel, otherwise from the latched request
  assign rd_addr_c = (r_state == R_IDLE) ? araddr : ar_addr_q;
  assign rd_len_c  = (r_state == R_IDLE) ? arlen  : ar_len_q;
  assign rd_size_c = (r_state == R_IDLE) ? arsize : ar_size_q;
  assign rd_id_c   = (r_state == R_IDLE) ? arid   : ar_id_q;
  assign rd_idx_c  = word_idx(rd_addr_c);
  assign rd_resp_c = resp_of(rd_addr_c, rd_len_c, rd_size_c);

  assign rd_done_c = (r_state == R_IDLE && ar_fire_c && delay_c == '0) ||
                     (r_state == R_DELAY && r_cnt == CNT_W'(1));
  assign wr_done_c = (w_state == W_DATA && w_fire_c && delay_c == '0) ||
                     (w_state == W_DELAY && w_cnt == CNT_W'(1));

  // Same-cycle write to the sampled word is forwarded so the read sees it
  always_comb begin
    rd_word_c = mem[rd_idx_c];
    if (w_fire_c && wr_resp_c == RESP_OKAY && wr_idx_c == rd_idx_c) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) rd_word_c[i*8 +: 8] = wdata[i*8 +: 8];
      end
    end
    if (rd_resp_c == RESP_DECERR) rd_word_c = '0;
  end

  always_ff @(posedge clock) begin
    if (w_fire_c && wr_resp_c == RESP_OKAY) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) mem[wr_idx_c][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= R_IDLE;
      r_cnt     <= '0;
      arready   <= 1'b1;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rdata     <= '0;
      rresp     <= '0;
      rid       <= '0;
      ar_addr_q <= '0;
      ar_id_q   <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
    end else begin
      if (rd_done_c) begin
        r_state <= R_RESP;
        rvalid  <= 1'b1;
        rlast   <= 1'b1;
        rdata   <= rd_word_c;
        rresp   <= rd_resp_c;
        rid     <= rd_id_c;
      end
      case (r_state)
        R_IDLE: begin
          if (ar_fire_c) begin
            arready   <= 1'b0;
            ar_addr_q <= araddr;
            ar_id_q   <= arid;
            ar_len_q  <= arlen;
            ar_size_q <= arsize;
            r_cnt     <= delay_c;
            if (delay_c != '0) r_state <= R_DELAY;
          end
        end
        R_DELAY: begin
          if (r_cnt != CNT_W'(1)) r_cnt <= r_cnt - CNT_W'(1);
        end
        R_RESP: begin
          if (rready) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state   <= W_IDLE;
      w_cnt     <= '0;
      awready   <= 1'b1;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= '0;
      bid       <= '0;
      aw_addr_q <= '0;
      aw_id_q   <= '0;
      aw_len_q  <= '0;
      aw_size_q <= '0;
    end else begin
      if (wr_done_c) begin
        w_state <= W_RESP;
        bvalid  <= 1'b1;
      end
      case (w_state)
        W_IDLE: begin
          if (aw_fire_c) begin
            w_state   <= W_DATA;
            awready   <= 1'b0;
            wready    <= 1'b1;
            aw_addr_q <= awaddr;
            aw_id_q   <= awid;
            aw_len_q  <= awlen;
            aw_size_q <= awsize;
          end
        end
        W_DATA: begin
          if (w_fire_c) begin
            wready <= 1'b0;
            bresp  <= wr_resp_c;
            bid    <= aw_id_q;
            w_cnt  <= delay_c;
            if (delay_c != '0) w_state <= W_DELAY;
          end
        end
        W_DELAY: begin
          if (w_cnt != CNT_W'(1)) w_cnt <= w_cnt - CNT_W'(1);
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_dsram_axi_slave.sv
// Directed bench: fixed-latency slave for function/boundary cases, plus a
// random-latency instance exercising back-to-back reads.
module tb_ysyx_23060208_dsram_axi_slave;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awid, bid, arid, rid;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;
  logic        arvalid, arready, rvalid, rready, rlast;

  logic        r2_arvalid, r2_arready, r2_rvalid, r2_rlast;
  logic [31:0] r2_araddr;
  logic [3:0]  r2_arid, r2_rid, r2_bid;
  logic [63:0] r2_rdata;
  logic [1:0]  r2_rresp, r2_bresp;
  logic        r2_awready, r2_wready, r2_bvalid;

  ysyx_23060208_dsram_axi_slave dut (
    .clock(clock), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  ysyx_23060208_dsram_axi_slave #(.RAND_DELAY(1'b1)) dut_r (
    .clock(clock), .reset(reset),
    .awvalid(1'b0), .awready(r2_awready), .awaddr(32'h0), .awid(4'h0), .awlen(8'h0),
    .awsize(3'h3), .awburst(2'b01),
    .wvalid(1'b0), .wready(r2_wready), .wdata(64'h0), .wstrb(8'h0), .wlast(1'b1),
    .bvalid(r2_bvalid), .bready(1'b1), .bresp(r2_bresp), .bid(r2_bid),
    .arvalid(r2_arvalid), .arready(r2_arready), .araddr(r2_araddr), .arid(r2_arid),
    .arlen(8'h0), .arsize(3'h3), .arburst(2'b01),
    .rvalid(r2_rvalid), .rready(1'b1), .rdata(r2_rdata), .rresp(r2_rresp),
    .rlast(r2_rlast), .rid(r2_rid)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // lat counts cycles from the W handshake to first bvalid (1 = next cycle)
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [63:0] data, input logic [7:0] strb,
                           output int lat, output logic [1:0] resp, output logic [3:0] idv);
    int b;
    awvalid = 1'b1; awaddr = addr; awid = id; awlen = len; awsize = size; awburst = 2'b01;
    b = 0;
    while (!awready && b < 20) begin tick(); b++; end
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = data; wstrb = strb; wlast = 1'b1;
    b = 0;
    while (!wready && b < 20) begin tick(); b++; end
    tick();
    wvalid = 1'b0;
    lat = 1;
    while (!bvalid && lat < 20) begin tick(); lat++; end
    resp = bresp; idv = bid;
    tick();
  endtask

  // Holds rready low for 'hold' cycles after rvalid, checking the response stays put
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [2:0] size, input int hold, output int lat,
                          output logic [63:0] data, output logic [1:0] resp,
                          output logic [3:0] idv, output logic lastv);
    int b;
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = 2'b01;
    rready = (hold == 0);
    b = 0;
    while (!arready && b < 20) begin tick(); b++; end
    tick();
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    data = rdata; resp = rresp; idv = rid; lastv = rlast;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_rdata", rdata, data);
      chk("hold_ctl", 64'({rvalid, rlast, rresp, rid, arready}), 64'({1'b1, lastv, resp, idv, 1'b0}));
    end
    rready = 1'b1;
    tick();
  endtask

  int          lat;
  logic [63:0] data;
  logic [1:0]  resp;
  logic [3:0]  idv;
  logic        lastv;
  logic [4:0]  seen;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1'b1;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 1'b1;
    r2_arvalid = 0; r2_araddr = 0; r2_arid = 0;
    seen = '0;
    repeat (3) tick();
    chk("rst_ready", 64'({arready, awready, wready}), 64'b110);
    chk("rst_valid", 64'({rvalid, bvalid, rlast}), 64'b000);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_ids", 64'({rresp, bresp, rid, bid}), 64'h0);
    reset = 1'b0;

    // W data offered before any AW must be refused
    wvalid = 1'b1; wdata = '1; wstrb = '1;
    tick(); tick();
    chk("w_before_aw", 64'(wready), 64'd0);
    wvalid = 1'b0;

    axi_write(32'h8000_0000, 4'h1, 8'h0, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, resp, idv);
    chk("pre_bresp", 64'(resp), 64'd0);

    axi_write(32'h8000_0010, 4'h5, 8'h0, 3'd3, 64'h1122_3344_5566_7788, 8'hFF, lat, resp, idv);
    chk("wr_lat", 64'(lat), 64'd3);
    chk("wr_bresp", 64'(resp), 64'd0);
    chk("wr_bid", 64'(idv), 64'h5);

    axi_read(32'h8000_0010, 4'h7, 8'h0, 3'd3, 5, lat, data, resp, idv, lastv);
    chk("rd_lat", 64'(lat), 64'd3);
    chk("rd_data", data, 64'h1122_3344_5566_7788);
    chk("rd_meta", 64'({idv, lastv, resp}), 64'({4'h7, 1'b1, 2'b00}));
    chk("rd_done", 64'({rvalid, arready}), 64'b01);

    axi_write(32'h8000_0010, 4'h2, 8'h0, 3'd3, 64'hAAAA_AAAA_0000_00BB, 8'h01, lat, resp, idv);
    axi_read(32'h8000_0010, 4'h3, 8'h0, 3'd3, 0, lat, data, resp, idv, lastv);
    chk("strb_data", data, 64'h1122_3344_5566_77BB);

    axi_write(32'h8000_1FF8, 4'h4, 8'h0, 3'd3, 64'hFEED_FACE_0BAD_F00D, 8'hFF, lat, resp, idv);
    chk("top_bresp", 64'(resp), 64'd0);
    axi_read(32'h8000_1FF8, 4'h4, 8'h0, 3'd3, 0, lat, data, resp, idv, lastv);
    chk("top_data", data, 64'hFEED_FACE_0BAD_F00D);
    axi_read(32'h8000_2000, 4'h6, 8'h0, 3'd3, 0, lat, data, resp, idv, lastv);
    chk("end_decerr", 64'({resp, data[31:0]}), 64'({2'b11, 32'h0}));
    axi_read(32'h7FFF_FFF8, 4'h6, 8'h0, 3'd3, 0, lat, data, resp, idv, lastv);
    chk("below_decerr", 64'(resp), 64'd3);
    axi_read(32'h2000_0000, 4'h6, 8'h0, 3'd3, 0, lat, data, resp, idv, lastv);
    chk("low_rresp", 64'(resp), 64'd3);
    chk("low_rdata", data, 64'h0);

    axi_write(32'h2000_0000, 4'h8, 8'h0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat, resp, idv);
    chk("low_bresp", 64'(resp), 64'd3);
    axi_write(32'h8000_2000, 4'h8, 8'h0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat, resp, idv);
    chk("end_bresp", 64'(resp), 64'd3);
    axi_write(32'h8000_0000, 4'h9, 8'h1, 3'd3, 64'h0, 8'hFF, lat, resp, idv);
    chk("awlen_slverr", 64'(resp), 64'd2);
    axi_read(32'h8000_0000, 4'h1, 8'h0, 3'd3, 0, lat, data, resp, idv, lastv);
    chk("word0_kept", data, 64'h0123_4567_89AB_CDEF);

    axi_read(32'h8000_0010, 4'hB, 8'h3, 3'd3, 0, lat, data, resp, idv, lastv);
    chk("arlen_slverr", 64'({resp, lastv}), 64'({2'b10, 1'b1}));
    axi_read(32'h8000_0010, 4'hB, 8'h0, 3'd4, 0, lat, data, resp, idv, lastv);
    chk("arsize_slverr", 64'(resp), 64'd2);

    // Reset while the write sits in W_DELAY: data stays written, no B ever
    awvalid = 1'b1; awaddr = 32'h8000_0018; awid = 4'h3; awlen = 0; awsize = 3'd3;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 64'h5555_6666_7777_8888; wstrb = 8'hFF;
    tick();
    wvalid = 1'b0;
    #2 reset = 1'b1;
    #1 chk("rst_mid", 64'({awready, wready, bvalid}), 64'b100);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_bvalid", 64'({bvalid, awready}), 64'b01);
    end
    axi_read(32'h8000_0018, 4'h2, 8'h0, 3'd3, 0, lat, data, resp, idv, lastv);
    chk("rst_kept_write", data, 64'h5555_6666_7777_8888);

    // Simultaneous AR/AW; W handshake lands in the same cycle the read samples
    axi_write(32'h8000_0020, 4'h1, 8'h0, 3'd3, 64'h0, 8'hFF, lat, resp, idv);
    arvalid = 1'b1; araddr = 32'h8000_0020; arid = 4'h9; arlen = 0; arsize = 3'd3;
    awvalid = 1'b1; awaddr = 32'h8000_0020; awid = 4'hA; awlen = 0; awsize = 3'd3;
    rready = 1'b1;
    chk("both_ready", 64'({arready, awready}), 64'b11);
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    chk("both_accepted", 64'({arready, awready, wready}), 64'b001);
    tick();
    wvalid = 1'b1; wdata = 64'hDEAD_BEEF_CAFE_F00D; wstrb = 8'hFF;
    chk("sim_not_yet", 64'(rvalid), 64'd0);
    tick();
    wvalid = 1'b0;
    chk("sim_rvalid", 64'({rvalid, rid}), 64'({1'b1, 4'h9}));
    chk("same_cycle_fwd", rdata, 64'hDEAD_BEEF_CAFE_F00D);
    tick();
    lat = 2;
    while (!bvalid && lat < 20) begin tick(); lat++; end
    chk("sim_blat", 64'(lat), 64'd3);
    chk("sim_bid", 64'({bresp, bid}), 64'({2'b00, 4'hA}));
    tick();

    // Random-latency instance: 200 back-to-back reads
    for (int i = 0; i < 200; i++) begin
      int b;
      r2_arvalid = 1'b1;
      r2_araddr = (i % 4 == 3) ? 32'h2000_0000 : 32'h8000_0000 + 32'(i * 8);
      r2_arid = 4'(i);
      b = 0;
      while (!r2_arready && b < 20) begin tick(); b++; end
      tick();
      r2_arvalid = 1'b0;
      lat = 1;
      while (!r2_rvalid && lat < 20) begin tick(); lat++; end
      chk("rand_lat", 64'(lat >= 1 && lat <= 4), 64'd1);
      chk("rand_rid", 64'({r2_rid, r2_rlast}), 64'({4'(i), 1'b1}));
      if (i % 4 == 3) chk("rand_decerr", 64'({r2_rresp, r2_rdata[31:0]}), 64'({2'b11, 32'h0}));
      else            chk("rand_okay", 64'(r2_rresp), 64'd0);
      if (lat <= 4) seen[lat] = 1'b1;
      tick();
    end
    chk("rand_spread", 64'($countones(seen) >= 2), 64'd1);
    chk("rand_wr_idle", 64'({r2_awready, r2_wready, r2_bvalid, r2_bresp, r2_bid}), 64'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
